// File: rtl/ultrasonic_pwm_core.sv
// Phase-shifted multi-channel PWM generator with a shadowed configuration set
// that is applied at period boundaries. Optional per-channel mask: ULTRASONIC_PWM_MASK_EN.

module ultrasonic_pwm_lane #(
  parameter int CNT_W = 16
) (
  input  logic [CNT_W-1:0] cnt,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] duty,
  input  logic [CNT_W-1:0] phase,
  input  logic             mask,
  input  logic             run,
  output logic             hi
);
  logic [CNT_W:0] pos;

  always_comb begin
    if (cnt >= phase) pos = {1'b0, cnt} - {1'b0, phase};
    else              pos = {1'b0, cnt} + {1'b0, period} - {1'b0, phase};
    // An out-of-range phase would alias into the period, so park the channel low.
    hi = run && !mask && (phase < period) && (pos < {1'b0, duty});
  end
endmodule

module ultrasonic_pwm_core #(
  parameter int NUM_CH = 8,
  parameter int CNT_W  = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic [CNT_W-1:0]        cfg_period,
  input  logic [CNT_W-1:0]        cfg_duty,
  input  logic [NUM_CH*CNT_W-1:0] cfg_phase,
  input  logic                    cfg_enable,
  input  logic                    cfg_load,
`ifdef ULTRASONIC_PWM_MASK_EN
  input  logic [NUM_CH-1:0]       cfg_mask,
`endif
  output logic                    cfg_busy,
  output logic [NUM_CH-1:0]       pwm_out,
  output logic                    cycle_sync
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  typedef struct packed {
    logic [CNT_W-1:0]             period;
    logic [CNT_W-1:0]             duty;
    logic [NUM_CH-1:0][CNT_W-1:0] phase;
    logic [NUM_CH-1:0]            mask;
  } cfg_t;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  cfg_t              act_q, act_d, pend_q, pend_d, cfg_in, new_cfg;
  logic              busy_q, busy_d;
  logic [NUM_CH-1:0] pwm_q, pwm_d;
  logic              sync_q, sync_d;
  logic              running, wrap, apply;

  always_comb begin
    cfg_in.period = cfg_period;
    cfg_in.duty   = cfg_duty;
    cfg_in.phase  = cfg_phase;
`ifdef ULTRASONIC_PWM_MASK_EN
    cfg_in.mask   = cfg_mask;
`else
    cfg_in.mask   = '0;
`endif
  end

  assign running = (state_q != IDLE);
  assign wrap    = running && (cnt_q == act_q.period - CNT_W'(1));
  // Pending values land either immediately (IDLE) or exactly at the wrap so a
  // new period always starts cleanly at cnt = 0.
  assign apply   = busy_q && (!running || wrap);
  assign new_cfg = apply ? pend_q : act_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    act_d   = new_cfg;
    pend_d  = cfg_load ? cfg_in : pend_q;
    busy_d  = cfg_load | (busy_q & ~apply);
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (cfg_enable && act_q.period >= CNT_W'(2)) state_d = RUN;
      end
      RUN, DRAIN: begin
        if (wrap) begin
          cnt_d = '0;
          if ((state_q == DRAIN && !cfg_enable) || new_cfg.period < CNT_W'(2))
            state_d = IDLE;
          else
            state_d = cfg_enable ? RUN : DRAIN;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = cfg_enable ? RUN : DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    sync_d = running && (cnt_q == '0);
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    ultrasonic_pwm_lane #(.CNT_W(CNT_W)) u_lane (
      .cnt    (cnt_q),
      .period (act_q.period),
      .duty   (act_q.duty),
      .phase  (act_q.phase[k]),
      .mask   (act_q.mask[k]),
      .run    (running),
      .hi     (pwm_d[k])
    );
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      act_q   <= '0;
      pend_q  <= '0;
      busy_q  <= 1'b0;
      pwm_q   <= '0;
      sync_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      pend_q  <= pend_d;
      busy_q  <= busy_d;
      pwm_q   <= pwm_d;
      sync_q  <= sync_d;
    end
  end

  assign cfg_busy   = busy_q;
  assign pwm_out    = pwm_q;
  assign cycle_sync = sync_q;
endmodule

// File: tb/tb_ultrasonic_pwm_core.sv
// Scoreboard bench for ultrasonic_pwm_core: a behavioural model queues the
// expected registered outputs each cycle; a negedge monitor pops and compares.

module tb_ultrasonic_pwm_core;
  localparam int NUM_CH = 8;
  localparam int CNT_W  = 16;

  logic                    ACLK = 1'b0;
  logic                    ARESETN = 1'b1;
  logic [CNT_W-1:0]        cfg_period = '0;
  logic [CNT_W-1:0]        cfg_duty = '0;
  logic [NUM_CH*CNT_W-1:0] cfg_phase = '0;
  logic                    cfg_enable = 1'b0;
  logic                    cfg_load = 1'b0;
  logic [NUM_CH-1:0]       cfg_mask = '0;
  logic                    cfg_busy;
  logic [NUM_CH-1:0]       pwm_out;
  logic                    cycle_sync;

  ultrasonic_pwm_core #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .ACLK       (ACLK),
    .ARESETN    (ARESETN),
    .cfg_period (cfg_period),
    .cfg_duty   (cfg_duty),
    .cfg_phase  (cfg_phase),
    .cfg_enable (cfg_enable),
    .cfg_load   (cfg_load),
`ifdef ULTRASONIC_PWM_MASK_EN
    .cfg_mask   (cfg_mask),
`endif
    .cfg_busy   (cfg_busy),
    .pwm_out    (pwm_out),
    .cycle_sync (cycle_sync)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [NUM_CH-1:0] pwm;
    logic              sync;
    logic              busy;
    int                cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc_no = 0;

  // Reference model: mode 0 idle, 1 running, 2 draining.
  int m_mode, m_cnt;
  int a_per, a_duty, a_ph[NUM_CH];
  int p_per, p_duty, p_ph[NUM_CH];
  bit a_mask[NUM_CH], p_mask[NUM_CH];
  bit p_v;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want, input int c);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h, expected %h", nm, c, got, want);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; p_v = 0;
    a_per = 0; a_duty = 0; p_per = 0; p_duty = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      a_ph[k] = 0; p_ph[k] = 0; a_mask[k] = 0; p_mask[k] = 0;
    end
    exp_q.delete();
  endtask

  task automatic model_step();
    exp_t e;
    bit   wrap, apply, en;
    int   nper;
    en = cfg_enable;
    e.cyc = cyc_no;
    e.pwm = '0;
    if (m_mode != 0)
      for (int k = 0; k < NUM_CH; k++)
        if (!a_mask[k] && a_ph[k] < a_per)
          e.pwm[k] = (((m_cnt - a_ph[k] + a_per) % a_per) < a_duty);
    e.sync = (m_mode != 0) && (m_cnt == 0);
    wrap  = (m_mode != 0) && (m_cnt == a_per - 1);
    apply = p_v && (m_mode == 0 || wrap);
    nper  = apply ? p_per : a_per;
    if (m_mode == 0) begin
      if (en && a_per >= 2) m_mode = 1;
      m_cnt = 0;
    end else if (wrap) begin
      m_cnt = 0;
      if ((m_mode == 2 && !en) || nper < 2) m_mode = 0;
      else m_mode = en ? 1 : 2;
    end else begin
      m_cnt++;
      m_mode = en ? 1 : 2;
    end
    if (apply) begin
      a_per = p_per; a_duty = p_duty;
      for (int k = 0; k < NUM_CH; k++) begin a_ph[k] = p_ph[k]; a_mask[k] = p_mask[k]; end
    end
    if (cfg_load) begin
      p_per = int'(cfg_period); p_duty = int'(cfg_duty);
      for (int k = 0; k < NUM_CH; k++) begin
        p_ph[k] = int'(cfg_phase[k*CNT_W +: CNT_W]);
`ifdef ULTRASONIC_PWM_MASK_EN
        p_mask[k] = cfg_mask[k];
`else
        p_mask[k] = 1'b0;
`endif
      end
    end
    p_v = cfg_load || (p_v && !apply);
    e.busy = p_v;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge ACLK);
    cyc_no++;
    model_step();
    #1;
  endtask

  task automatic cyc(input int n);
    repeat (n) tick();
  endtask

  task automatic set_phase(input int k, input int v);
    cfg_phase[k*CNT_W +: CNT_W] = CNT_W'(v);
  endtask

  task automatic load(input int per, input int duty);
    cfg_period = CNT_W'(per);
    cfg_duty   = CNT_W'(duty);
    cfg_load   = 1'b1;
    tick();
    cfg_load   = 1'b0;
  endtask

  task automatic wait_cnt(input int target);
    int n;
    n = 0;
    while (m_cnt != target && n < 40) begin tick(); n++; end
    chk("reach_cnt", 64'(m_cnt), 64'(target), cyc_no);
  endtask

  task automatic do_reset();
    cfg_load = 1'b0;
    #2 ARESETN = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_pwm",  64'(pwm_out),    64'(0), cyc_no);
    chk("rst_sync", 64'(cycle_sync), 64'(0), cyc_no);
    chk("rst_busy", 64'(cfg_busy),   64'(0), cyc_no);
    model_reset();
    @(posedge ACLK);
    @(posedge ACLK);
    #3 ARESETN = 1'b1;
  endtask

  always @(negedge ACLK) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("pwm_out",    64'(pwm_out),    64'(e.pwm),  e.cyc);
      chk("cycle_sync", 64'(cycle_sync), 64'(e.sync), e.cyc);
      chk("cfg_busy",   64'(cfg_busy),   64'(e.busy), e.cyc);
    end
  end

  initial begin
    model_reset();
    #2;
    do_reset();

    // Equal phases: all channels high 5, low 5, sync every 10.
    load(10, 5);
    cfg_enable = 1'b1;
    cyc(32);

    // Staggered phases.
    set_phase(1, 2); set_phase(2, 4); set_phase(3, 6); set_phase(4, 8);
    load(10, 3);
    cyc(30);

    // Period change mid-run lands at the wrap.
    wait_cnt(3);
    load(20, 5);
    cyc(45);

    // Duty and phase boundaries.
    load(10, 0);  cyc(25);
    load(10, 12); cyc(25);
    set_phase(2, 15);
    load(10, 3);  cyc(25);
    // Back-to-back loads: only the latest applies.
    load(7, 2); load(9, 4); cyc(25);

    // Drain then idle.
    load(10, 5); cyc(12);
    wait_cnt(4);
    cfg_enable = 1'b0;
    cyc(20);

    // Reset mid-period, then stays idle until a legal load.
    cfg_enable = 1'b1;
    cyc(3);
    wait_cnt(6);
    do_reset();
    cyc(10);
    load(1, 1); cyc(10);
    load(10, 3); cyc(15);
    // Illegal period applied at a wrap forces idle.
    load(1, 1); cyc(20);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) cfg_enable = ~cfg_enable;
      if ($urandom_range(0, 14) == 0) begin
        cfg_period = CNT_W'(($urandom_range(0, 9) == 0) ? $urandom_range(0, 1) : $urandom_range(2, 24));
        cfg_duty   = CNT_W'($urandom_range(0, 26));
        for (int k = 0; k < NUM_CH; k++) set_phase(k, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 26) : $urandom_range(0, 8));
        cfg_mask   = NUM_CH'($urandom_range(0, 255));
        cfg_load   = 1'b1;
      end
      if ($urandom_range(0, 999) == 0) do_reset();
      else tick();
      cfg_load = 1'b0;
    end

    @(negedge ACLK);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ultrasonic_pwm_core.md
ULTRASONIC_PWM_CORE -- requirements
Module: ultrasonic_pwm_core

Interface
REQ-001 Parameter NUM_CH, default 8: number of transducer channels.
REQ-002 Parameter CNT_W, default 16: width of period, duty and phase values.
REQ-003 ACLK  in  1  single clock; all state on rising edge.
REQ-004 ARESETN  in  1  asynchronous, active-low reset.
REQ-005 cfg_period  in  CNT_W  PWM period in ACLK cycles; legal 2..2^CNT_W-1.
REQ-006 cfg_duty  in  CNT_W  high time in cycles, common to all channels.
REQ-007 cfg_phase  in  NUM_CH*CNT_W  per-channel phase offset; channel k at bits [k*CNT_W +: CNT_W].
REQ-008 cfg_enable  in  1  level; run request.
REQ-009 cfg_load  in  1  single-cycle strobe; captures cfg_period/duty/phase into pending shadow.
REQ-010 cfg_busy  out  1  high while a pending shadow is not yet applied.
REQ-011 pwm_out  out  NUM_CH  registered per-channel drive.
REQ-012 cycle_sync  out  1  one-cycle pulse, coincident with the pwm_out update for counter value 0.

Function
REQ-013 States IDLE, RUN, DRAIN; IDLE->RUN when cfg_enable=1 and active period >=2; RUN->DRAIN when cfg_enable=0; DRAIN->IDLE at end of current period; DRAIN->RUN if cfg_enable returns before the wrap.
REQ-014 Counter cnt: 0 in IDLE; in RUN/DRAIN increments each cycle, wraps to 0 after active_period-1.
REQ-015 cfg_load copies inputs to pending and sets cfg_busy next cycle.
REQ-016 Pending applies to active set: in IDLE the cycle after capture; in RUN/DRAIN on the wrap cycle (cnt=active_period-1), so the new period starts at cnt=0.
REQ-017 cfg_load while cfg_busy overwrites pending; only the latest values apply; cfg_busy stays high.
REQ-018 cfg_load on the wrap cycle: previous pending (if any) applies at this wrap; new values become pending for the next wrap.
REQ-019 cfg_busy clears the cycle after apply.
REQ-020 Per channel: pos = cnt-phase if cnt>=phase else cnt+period-phase, computed at CNT_W+1 bits; pwm high iff pos<duty.
REQ-021 duty=0 -> channel low; duty>=period -> channel constantly high while RUN/DRAIN.
REQ-022 phase>=period -> that channel held low.
REQ-023 pwm_out and cycle_sync are registered: one ACLK latency from cnt.
REQ-024 pwm_out all low in IDLE; cycle_sync 0 in IDLE.
REQ-025 Active period <2 blocks IDLE->RUN; a pending period <2 applied during RUN forces IDLE at that wrap.

Reset
REQ-026 ARESETN low asynchronously forces: state IDLE, cnt 0, active and pending sets 0, cfg_busy 0, pwm_out 0, cycle_sync 0.
REQ-027 Reset mid-period discards pending; after release block stays IDLE until a cfg_load of legal values.

Configuration
REQ-028 Macro ULTRASONIC_PWM_MASK_EN defined: adds input cfg_mask (NUM_CH), shadowed with cfg_load like other cfg; masked channel (bit=1) held low.
REQ-029 Macro undefined: no cfg_mask port; all channels unmasked; behaviour otherwise identical.

Verification
REQ-030 Reset, load period=10 duty=5 phase all 0, enable -> all pwm_out high 5 cycles, low 5, cycle_sync every 10 cycles.
REQ-031 Phases 0,2,4,6,8,0,0,0 period=10 duty=3 -> channel 1 rises 2 cycles after channel 0; channel 4 (phase 8) high at cnt 8,9,0.
REQ-032 During RUN, load period=20 at cnt=3 -> cfg_busy high until wrap; next period is 20 cycles; cfg_busy low cycle after wrap.
REQ-033 duty=0 / duty=12 with period=10 / phase=15 on channel 2 -> low / constant high / channel 2 low.
REQ-034 Deassert enable at cnt=4 -> outputs continue to cnt 9, then IDLE, pwm_out 0; ARESETN low at cnt=6 -> all outputs 0 immediately.
REQ-035 With ULTRASONIC_PWM_MASK_EN, mask=8'h01 loaded -> channel 0 low from next period, others unchanged.
